// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode classes, immediate/PC-select codes and FSM type for the pipeline sequencer.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package pipe_ctrl_pkg;

  // Opcode classes taken from instruction[6:2]
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_ARI_I  = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  // Immediate-format select for the X-stage immediate generator
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  // Next-PC source select
  localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SEL_BR    = 2'd1;
  localparam logic [1:0] PC_SEL_JALR  = 2'd2;
  localparam logic [1:0] PC_SEL_HOLD  = 2'd3;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic {ST_RUN, ST_MEM_WAIT} state_t;

  function automatic logic [4:0] opc(input logic [31:0] inst);
    return inst[6:2];
  endfunction

endpackage

// File: rtl/pipe_hazard_unit.sv
// W-to-X forwarding selects and W-stage writeback enable.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the stage shadows directly.
module pipe_hazard_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] opc_x,
  input  logic [4:0] rs1_x,
  input  logic [4:0] rs2_x,
  input  logic [4:0] opc_w,
  input  logic [4:0] rd_w,
  input  logic       valid_w,
  output logic       wb_en,
  output logic       fwd_a,
  output logic       fwd_b
);

  logic w_writes;
  logic x_uses_rs1;
  logic x_uses_rs2;

  // Classify which register fields each stage actually uses
  always_comb begin
    w_writes   = (opc_w == OP_R)   || (opc_w == OP_ARI_I) || (opc_w == OP_LOAD) ||
                 (opc_w == OP_LUI) || (opc_w == OP_AUIPC) || (opc_w == OP_JAL)  ||
                 (opc_w == OP_JALR);
    x_uses_rs1 = !((opc_x == OP_LUI) || (opc_x == OP_AUIPC) || (opc_x == OP_JAL));
    x_uses_rs2 = (opc_x == OP_R) || (opc_x == OP_STORE) || (opc_x == OP_BRANCH);
  end

  // x0 is never a forwarding source, so rd_w==0 suppresses writeback and both selects
  always_comb begin
    wb_en = valid_w && w_writes && (rd_w != 5'd0);
    fwd_a = wb_en && x_uses_rs1 && (rs1_x == rd_w);
    fwd_b = wb_en && x_uses_rs2 && (rs2_x == rd_w);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Sequencer for the F/X/W pipeline: PC select, stall/flush, forwarding and dmem handshake.
// Latency: controls are combinational from the X/W shadows; shadows advance one stage per edge.
// Backpressure: an unacked X-stage memory access stalls the whole pipe until dmem_ack.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_f,
  input  logic             imem_valid,
  input  logic             br_taken,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic [1:0]       pc_sel,
  output logic             stall,
  output logic [31:0]      inst_x,
  output logic [2:0]       imm_type,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             wb_en,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  state_t      state_q, state_d;
  logic [31:0] inst_x_q, inst_w_q;
  logic        valid_x, valid_w;
  logic [4:0]  opc_x;
  logic        inject_nop;
  logic        unused_w_bits;

  assign opc_x  = opc(inst_x_q);
  assign inst_x = inst_x_q;

  // Only opcode and rd of the W shadow feed control; the rest is kept for visibility
  assign unused_w_bits = ^{inst_w_q[31:12], inst_w_q[1:0]};

  // Memory handshake; the stall is combinational so the freeze takes effect this cycle
  always_comb begin
    dmem_req = valid_x && ((opc_x == OP_LOAD) || (opc_x == OP_STORE));
    stall    = dmem_req && !dmem_ack;
  end

  // Next state and PC select: stall > redirect > fetch bubble > normal
  always_comb begin
    state_d    = state_q;
    pc_sel     = PC_SEL_PLUS4;
    inject_nop = 1'b0;
    if (stall) begin
      state_d = ST_MEM_WAIT;
      pc_sel  = PC_SEL_HOLD;
    end else begin
      state_d = ST_RUN;
      if (valid_x && ((opc_x == OP_JAL) || ((opc_x == OP_BRANCH) && br_taken))) begin
        pc_sel     = PC_SEL_BR;
        inject_nop = 1'b1;
      end else if (valid_x && (opc_x == OP_JALR)) begin
        pc_sel     = PC_SEL_JALR;
        inject_nop = 1'b1;
      end else if (!imem_valid) begin
        pc_sel     = PC_SEL_HOLD;
        inject_nop = 1'b1;
      end
    end
  end

  // Immediate format for the instruction sitting in X
  always_comb begin
    imm_type = IMM_NONE;
    case (opc_x)
      OP_ARI_I, OP_LOAD, OP_JALR: imm_type = IMM_I;
      OP_STORE:                   imm_type = IMM_S;
      OP_BRANCH:                  imm_type = IMM_B;
      OP_LUI, OP_AUIPC:           imm_type = IMM_U;
      OP_JAL:                     imm_type = IMM_J;
      default:                    imm_type = IMM_NONE;
    endcase
  end

  // FSM state register; a reset abandons any outstanding access
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Stage shadows and performance counters; everything freezes while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_x_q   <= NOP_INST;
      inst_w_q   <= NOP_INST;
      valid_x    <= 1'b0;
      valid_w    <= 1'b0;
      bubble_cnt <= '0;
      retire_cnt <= '0;
    end else if (!stall) begin
      inst_w_q <= inst_x_q;
      valid_w  <= valid_x;
      if (valid_w) retire_cnt <= retire_cnt + CNT_W'(1);
      if (inject_nop) begin
        inst_x_q   <= NOP_INST;
        valid_x    <= 1'b0;
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end else begin
        inst_x_q <= inst_f;
        valid_x  <= 1'b1;
      end
    end
  end

  pipe_hazard_unit u_hazard (
    .opc_x   (opc_x),
    .rs1_x   (inst_x_q[19:15]),
    .rs2_x   (inst_x_q[24:20]),
    .opc_w   (opc(inst_w_q)),
    .rd_w    (inst_w_q[11:7]),
    .valid_w (valid_w),
    .wb_en   (wb_en),
    .fwd_a   (fwd_a),
    .fwd_b   (fwd_b)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a cycle-level reference model and literal spot checks.
// Latency: model predicts outputs each cycle from its own stage view and the live inputs.
// Backpressure: dmem_ack is held low for several cycles to exercise the stall path.
module tb_pipe_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADDI1  = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] ADDI2  = 32'h0010_8113; // addi x2,x1,1
  localparam logic [31:0] BEQ    = 32'h0000_0463; // beq x0,x0,8
  localparam logic [31:0] LW1    = 32'h0000_2083; // lw x1,0(x0)
  localparam logic [31:0] SW     = 32'h0011_2023; // sw x1,0(x2)
  localparam logic [31:0] ADDI0  = 32'h0070_0013; // addi x0,x0,7
  localparam logic [31:0] ADDI4  = 32'h0010_0213; // addi x4,x0,1
  localparam logic [31:0] JAL    = 32'h0080_00EF; // jal x1,8
  localparam logic [31:0] JALR   = 32'h0000_8067; // jalr x0,0(x1)
  localparam logic [31:0] LUI    = 32'h1234_52B7; // lui x5,0x12345
  localparam logic [31:0] ADD    = 32'h0020_8333; // add x6,x1,x2

  logic        clk = 1'b0;
  logic        rst, imem_valid, br_taken, dmem_ack;
  logic [31:0] inst_f;
  logic        dmem_req, stall, fwd_a, fwd_b, wb_en;
  logic [1:0]  pc_sel;
  logic [31:0] inst_x;
  logic [2:0]  imm_type;
  logic [31:0] bubble_cnt, retire_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .inst_f     (inst_f),
    .imem_valid (imem_valid),
    .br_taken   (br_taken),
    .dmem_ack   (dmem_ack),
    .dmem_req   (dmem_req),
    .pc_sel     (pc_sel),
    .stall      (stall),
    .inst_x     (inst_x),
    .imm_type   (imm_type),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .wb_en      (wb_en),
    .bubble_cnt (bubble_cnt),
    .retire_cnt (retire_cnt)
  );

  // ---------------- reference model ----------------
  // Instruction kinds and per-kind property tables
  // order: LOAD ARI AUIPC STORE R LUI BR JALR JAL OTHER
  localparam int K_LOAD = 0, K_ARI = 1, K_AUIPC = 2, K_STORE = 3, K_R = 4,
                 K_LUI = 5, K_BR = 6, K_JALR = 7, K_JAL = 8, K_OTHER = 9;
  int imm_of [10] = '{1, 1, 4, 2, 0, 4, 3, 1, 5, 0};
  int writes [10] = '{1, 1, 1, 0, 1, 1, 0, 1, 1, 0};
  int uses1  [10] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
  int uses2  [10] = '{0, 0, 0, 1, 1, 0, 1, 0, 0, 0};

  function automatic int kind(input logic [31:0] i);
    case (int'(i[6:2]))
      0:       return K_LOAD;
      4:       return K_ARI;
      5:       return K_AUIPC;
      8:       return K_STORE;
      12:      return K_R;
      13:      return K_LUI;
      24:      return K_BR;
      25:      return K_JALR;
      27:      return K_JAL;
      default: return K_OTHER;
    endcase
  endfunction

  logic [31:0] mx, mw;
  logic        mvx, mvw;
  int unsigned mbub, mret;
  bit          model_ok = 1'b0;

  logic        e_req, e_stall, e_wb, e_fa, e_fb, e_nop;
  logic [1:0]  e_pc;
  int          kx, kw;

  always_comb begin
    kx      = kind(mx);
    kw      = kind(mw);
    e_req   = mvx && (kx == K_LOAD || kx == K_STORE);
    e_stall = e_req && !dmem_ack;
    e_nop   = 1'b0;
    e_pc    = 2'd0;
    if (e_stall) e_pc = 2'd3;
    else if (mvx && (kx == K_JAL || (kx == K_BR && br_taken))) begin e_pc = 2'd1; e_nop = 1'b1; end
    else if (mvx && kx == K_JALR) begin e_pc = 2'd2; e_nop = 1'b1; end
    else if (!imem_valid) begin e_pc = 2'd3; e_nop = 1'b1; end
    e_wb = mvw && (writes[kw] == 1) && (mw[11:7] != 5'd0);
    e_fa = e_wb && (uses1[kx] == 1) && (mx[19:15] == mw[11:7]);
    e_fb = e_wb && (uses2[kx] == 1) && (mx[24:20] == mw[11:7]);
  end

  // Model advance: one stage per unstalled edge
  always @(posedge clk) begin
    if (rst) begin
      mx = NOP; mw = NOP; mvx = 1'b0; mvw = 1'b0; mbub = 0; mret = 0;
      model_ok = 1'b1;
    end else if (model_ok && !e_stall) begin
      if (mvw) mret = mret + 1;
      mw  = mx;
      mvw = mvx;
      if (e_nop) begin mx = NOP; mvx = 1'b0; mbub = mbub + 1; end
      else       begin mx = inst_f; mvx = 1'b1; end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_dmem_req", 32'(dmem_req), 32'(e_req));
      chk("m_stall", 32'(stall), 32'(e_stall));
      chk("m_pc_sel", 32'(pc_sel), 32'(e_pc));
      chk("m_inst_x", inst_x, mx);
      chk("m_imm_type", 32'(imm_type), 32'(imm_of[kx]));
      chk("m_wb_en", 32'(wb_en), 32'(e_wb));
      chk("m_fwd_a", 32'(fwd_a), 32'(e_fa));
      chk("m_fwd_b", 32'(fwd_b), 32'(e_fb));
      chk("m_bubble_cnt", bubble_cnt, mbub);
      chk("m_retire_cnt", retire_cnt, mret);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic r, input logic [31:0] i, input logic iv,
                     input logic bt, input logic ack);
    @(posedge clk);
    #1;
    rst = r; inst_f = i; imem_valid = iv; br_taken = bt; dmem_ack = ack;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; inst_f = NOP; imem_valid = 1'b1; br_taken = 1'b0; dmem_ack = 1'b0;
    cyc(1, NOP, 1, 0, 0);
    cyc(1, NOP, 1, 0, 0);
    chk("rst_inst_x", inst_x, NOP);
    chk("rst_imm_type", 32'(imm_type), 32'd1);
    chk("rst_pc_sel", 32'(pc_sel), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_fwd", 32'({wb_en, fwd_a, fwd_b}), 32'd0);
    chk("rst_counters", bubble_cnt | retire_cnt, 32'd0);

    // Forwarding between back-to-back dependent addi
    cyc(0, ADDI1, 1, 0, 1);
    cyc(0, ADDI2, 1, 0, 1);
    cyc(0, NOP, 1, 0, 1);
    chk("fwd_inst_x", inst_x, ADDI2);
    chk("fwd_a_set", 32'(fwd_a), 32'd1);
    cyc(0, NOP, 1, 0, 1);
    cyc(0, BEQ, 1, 0, 1);
    chk("retire_two", retire_cnt, 32'd2);

    // Taken branch squashes one fetched instruction
    cyc(0, ADD, 1, 1, 1);
    chk("br_pc_sel", 32'(pc_sel), 32'd1);
    chk("br_imm_b", 32'(imm_type), 32'd3);
    chk("br_bub_before", bubble_cnt, 32'd0);
    cyc(0, LW1, 1, 0, 0);
    chk("br_squash", inst_x, NOP);
    chk("br_bub_after", bubble_cnt, 32'd1);

    // Load waits three cycles for ack
    for (int k = 0; k < 3; k++) begin
      cyc(0, SW, 1, 0, 0);
      chk("ld_stall", 32'(stall), 32'd1);
      chk("ld_pc_hold", 32'(pc_sel), 32'd3);
      chk("ld_inst_x", inst_x, LW1);
      chk("ld_retire", retire_cnt, 32'd5);
    end
    cyc(0, SW, 1, 0, 1);
    chk("ld_ack_go", 32'(stall), 32'd0);
    cyc(0, ADDI0, 1, 0, 1);
    chk("st_inst_x", inst_x, SW);
    chk("st_fwd_b", 32'(fwd_b), 32'd1);
    chk("st_imm_s", 32'(imm_type), 32'd2);

    // Write to x0 never forwards
    cyc(0, ADDI4, 1, 0, 1);
    cyc(0, NOP, 0, 0, 1);
    chk("x0_wb_en", 32'(wb_en), 32'd0);
    chk("x0_fwd_a", 32'(fwd_a), 32'd0);
    chk("fb_pc_hold", 32'(pc_sel), 32'd3);
    cyc(0, NOP, 0, 0, 1);
    cyc(0, JAL, 1, 0, 1);
    chk("fb_bubbles", bubble_cnt, 32'd3);
    chk("fb_retire", retire_cnt, 32'd9);

    // JAL redirects even with imem_valid low; JALR uses the other PC source
    cyc(0, ADD, 0, 0, 1);
    chk("jal_pc_sel", 32'(pc_sel), 32'd1);
    chk("jal_imm_j", 32'(imm_type), 32'd5);
    cyc(0, JALR, 1, 0, 1);
    cyc(0, LUI, 1, 0, 1);
    chk("jalr_pc_sel", 32'(pc_sel), 32'd2);
    cyc(0, LUI, 1, 0, 1);
    cyc(0, ADD, 1, 0, 1);
    chk("lui_imm_u", 32'(imm_type), 32'd4);
    cyc(0, LW1, 1, 0, 1);
    chk("r_imm_none", 32'(imm_type), 32'd0);
    chk("mid_retire", retire_cnt, 32'd11);
    chk("mid_bubbles", bubble_cnt, 32'd5);

    // Reset while waiting on memory
    cyc(0, NOP, 1, 0, 0);
    chk("mw_stall", 32'(stall), 32'd1);
    cyc(1, NOP, 1, 0, 0);
    cyc(0, NOP, 1, 0, 0);
    chk("rstmw_dmem_req", 32'(dmem_req), 32'd0);
    chk("rstmw_stall", 32'(stall), 32'd0);
    chk("rstmw_counters", bubble_cnt | retire_cnt, 32'd0);
    cyc(0, ADDI1, 1, 0, 1);
    cyc(0, NOP, 1, 0, 1);
    cyc(0, NOP, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
